// File: rtl/nes_pad_if.sv
// nes_pad_if: bundles the pad-side and local-side signals of the NES pad
// responder.
//
// Signals:
//   buttons, buttons_we : local button write port. buttons is captured on
//                         every rising clk edge where buttons_we is high.
//   pad_latch, pad_clk  : console strobe and read clock. Both are
//                         asynchronous to clk.
//   pad_data_n          : serial data back to the console, active low.
//   bit_count           : bits shifted since the last latch release.
//   read_done           : one-cycle pulse on the 8th shift.
//   extra_reads         : sticky flag for shifts past the 8th.
//   fsm_state           : debug view of the responder state machine.
//
// Handshake: there is no valid/ready pair. buttons_we is a write strobe
// that is always accepted in the cycle it is high. pad_latch and pad_clk
// are level/edge signals with no flow control.
interface nes_pad_if;
  logic [7:0] buttons;
  logic       buttons_we;
  logic       pad_latch;
  logic       pad_clk;
  logic       pad_data_n;
  logic [3:0] bit_count;
  logic       read_done;
  logic       extra_reads;
  logic [1:0] fsm_state;

  modport master (
    output buttons, buttons_we, pad_latch, pad_clk,
    input  pad_data_n, bit_count, read_done, extra_reads, fsm_state
  );

  modport slave (
    input  buttons, buttons_we, pad_latch, pad_clk,
    output pad_data_n, bit_count, read_done, extra_reads, fsm_state
  );
endinterface

// File: rtl/nes_pad_responder.sv
// nes_pad_responder: emulates a standard NES pad's 8-bit shift register.
// The console's latch/clock are synchronized and filtered. The block then
// answers with A, B, Select, Start, Up, Down, Left, Right on pad_data_n,
// which is active low.
//
// Ports:
//   clk : system clock; all logic runs on its rising edge.
//   rst : synchronous, active-high reset.
//   pad : nes_pad_if.slave. Carries the button write port, the console
//         pins, and the status/debug outputs.
module nes_pad_responder #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 2
) (
  input logic      clk,
  input logic      rst,
  nes_pad_if.slave pad
);

  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_LATCH     = 2'd0,
    ST_SHIFT     = 2'd1,
    ST_EXHAUSTED = 2'd2
  } state_t;

  // Input path. Channel 0 is pad_latch and channel 1 is pad_clk.
  logic [SYNC_STAGES-1:0] sync_latch;
  logic [SYNC_STAGES-1:0] sync_clk;
  logic [1:0]             s_in;
  logic [1:0]             filt;
  logic [1:0]             filt_prev;
  logic [CW-1:0]          fcnt [2];

  assign s_in = {sync_clk[SYNC_STAGES-1], sync_latch[SYNC_STAGES-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_latch <= '0;
      sync_clk   <= '0;
      filt       <= '0;
      filt_prev  <= '0;
      fcnt[0]    <= '0;
      fcnt[1]    <= '0;
    end else begin
      sync_latch <= {sync_latch[SYNC_STAGES-2:0], pad.pad_latch};
      sync_clk   <= {sync_clk[SYNC_STAGES-2:0], pad.pad_clk};
      filt_prev  <= filt;
      for (int i = 0; i < 2; i++) begin
        // The filtered value follows the synchronized value only after
        // FILTER_CYCLES consecutive cycles of disagreement.
        if (s_in[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == CW'(FILTER_CYCLES - 1)) begin
          filt[i] <= s_in[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + CW'(1);
        end
      end
    end
  end

  logic latch_f;
  logic clk_rise;

  assign latch_f  = filt[0];
  assign clk_rise = filt[1] & ~filt_prev[1];

  // Pad state machine.
  state_t     state, state_next;
  logic [7:0] hold, hold_next;
  logic [7:0] sr, sr_next;
  logic [3:0] cnt, cnt_next;
  logic       done, done_next;
  logic       extra, extra_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_SHIFT;
      hold  <= 8'h00;
      sr    <= 8'h00;
      cnt   <= 4'd8;
      done  <= 1'b0;
      extra <= 1'b0;
    end else begin
      state <= state_next;
      hold  <= hold_next;
      sr    <= sr_next;
      cnt   <= cnt_next;
      done  <= done_next;
      extra <= extra_next;
    end
  end

  always_comb begin
    state_next = state;
    hold_next  = pad.buttons_we ? pad.buttons : hold;
    sr_next    = sr;
    cnt_next   = cnt;
    done_next  = 1'b0;
    extra_next = extra;

    if (latch_f) begin
      // A latch level takes priority over any clock edge seen in the same
      // cycle, and it aborts any read in progress. A same-cycle button
      // write goes straight into the shift register.
      state_next = ST_LATCH;
      sr_next    = pad.buttons_we ? pad.buttons : hold;
      cnt_next   = 4'd0;
      extra_next = 1'b0;
    end else begin
      case (state)
        ST_LATCH: begin
          state_next = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (clk_rise) begin
            // The shifted-in 1 makes late reads return "pressed".
            sr_next = {1'b1, sr[7:1]};
            if (cnt == 4'd7) begin
              cnt_next   = 4'd8;
              done_next  = 1'b1;
              state_next = ST_EXHAUSTED;
            end else if (cnt < 4'd8) begin
              cnt_next = cnt + 4'd1;
            end
          end
        end
        ST_EXHAUSTED: begin
          sr_next = 8'hFF;
          if (clk_rise) begin
            extra_next = 1'b1;
          end
        end
        default: begin
          state_next = ST_SHIFT;
        end
      endcase
    end
  end

  assign pad.pad_data_n  = ~sr[0];
  assign pad.bit_count   = cnt;
  assign pad.read_done   = done;
  assign pad.extra_reads = extra;
  assign pad.fsm_state   = state;

endmodule

// File: tb/tb_nes_pad_responder.sv
// tb_nes_pad_responder: directed bench for nes_pad_responder with the
// default SYNC_STAGES=2 and FILTER_CYCLES=2. Console timing uses a 12 us
// latch (600 cycles) and 6 us clock phases (300 cycles) at 50 MHz.
module tb_nes_pad_responder;

  localparam int LC = 600;
  localparam int PH = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   done_seen = 0;

  nes_pad_if bus ();

  nes_pad_responder #(.SYNC_STAGES(2), .FILTER_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .pad (bus.slave)
  );

  // Clock and read_done pulse monitor.
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (bus.read_done) done_seen++;
  end

  // Driver tasks.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_buttons(input logic [7:0] v);
    bus.buttons    = v;
    bus.buttons_we = 1'b1;
    step(1);
    bus.buttons_we = 1'b0;
  endtask

  task automatic do_latch();
    bus.pad_latch = 1'b1;
    step(LC);
    bus.pad_latch = 1'b0;
    step(PH);
  endtask

  task automatic pulse_clk();
    bus.pad_clk = 1'b1;
    step(PH);
    bus.pad_clk = 1'b0;
    step(PH);
  endtask

  // Tests.
  task automatic test_reset();
    chk_cnt++;
    if (bus.pad_data_n !== 1'b1) $display("FAIL reset_data_n: got %b expected 1", bus.pad_data_n);
    else pass_cnt++;
    chk_cnt++;
    if (bus.bit_count !== 4'd8) $display("FAIL reset_bit_count: got %0d expected 8", bus.bit_count);
    else pass_cnt++;
    chk_cnt++;
    if (bus.read_done !== 1'b0) $display("FAIL reset_read_done: got %b expected 0", bus.read_done);
    else pass_cnt++;
    chk_cnt++;
    if (bus.extra_reads !== 1'b0) $display("FAIL reset_extra_reads: got %b expected 0", bus.extra_reads);
    else pass_cnt++;
  endtask

  task automatic test_read_81();
    logic [7:0] exp_n;
    int first_done;
    int highs;
    int seen0;
    exp_n = 8'b0111_1110;
    seen0 = done_seen;
    write_buttons(8'h81);
    bus.pad_latch = 1'b1;
    step(LC);
    chk_cnt++;
    if (bus.bit_count !== 4'd0) $display("FAIL read81_latch_count: got %0d expected 0", bus.bit_count);
    else pass_cnt++;
    bus.pad_latch = 1'b0;
    step(PH);
    for (int i = 0; i < 8; i++) begin
      chk_cnt++;
      if (bus.pad_data_n !== exp_n[i]) $display("FAIL read81_bit%0d: got %b expected %b", i, bus.pad_data_n, exp_n[i]);
      else pass_cnt++;
      if (i < 7) pulse_clk();
    end
    // The 8th pulse is tracked cycle by cycle to time read_done.
    first_done = 0;
    highs = 0;
    bus.pad_clk = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (bus.read_done === 1'b1) begin
        highs++;
        if (first_done == 0) first_done = i;
      end
    end
    step(PH - 10);
    bus.pad_clk = 1'b0;
    step(PH);
    chk_cnt++;
    if (first_done != 5) $display("FAIL read81_done_latency: got %0d expected 5", first_done);
    else pass_cnt++;
    chk_cnt++;
    if (highs != 1) $display("FAIL read81_done_width: got %0d expected 1", highs);
    else pass_cnt++;
    chk_cnt++;
    if (done_seen - seen0 != 1) $display("FAIL read81_done_total: got %0d expected 1", done_seen - seen0);
    else pass_cnt++;
    chk_cnt++;
    if (bus.bit_count !== 4'd8) $display("FAIL read81_count: got %0d expected 8", bus.bit_count);
    else pass_cnt++;
    chk_cnt++;
    if (bus.extra_reads !== 1'b0) $display("FAIL read81_extra: got %b expected 0", bus.extra_reads);
    else pass_cnt++;
  endtask

  task automatic test_extra_reads();
    for (int i = 0; i < 3; i++) begin
      pulse_clk();
      chk_cnt++;
      if (bus.pad_data_n !== 1'b0) $display("FAIL extra_data_n%0d: got %b expected 0", i, bus.pad_data_n);
      else pass_cnt++;
    end
    chk_cnt++;
    if (bus.extra_reads !== 1'b1) $display("FAIL extra_set: got %b expected 1", bus.extra_reads);
    else pass_cnt++;
    chk_cnt++;
    if (bus.bit_count !== 4'd8) $display("FAIL extra_count: got %0d expected 8", bus.bit_count);
    else pass_cnt++;
    do_latch();
    chk_cnt++;
    if (bus.extra_reads !== 1'b0) $display("FAIL extra_cleared: got %b expected 0", bus.extra_reads);
    else pass_cnt++;
  endtask

  // Starts right after a latch of hold = 8'h81.
  task automatic test_glitch();
    pulse_clk();
    pulse_clk();
    bus.pad_clk = 1'b1;
    step(1);
    bus.pad_clk = 1'b0;
    step(12);
    chk_cnt++;
    if (bus.bit_count !== 4'd2) $display("FAIL glitch_count: got %0d expected 2", bus.bit_count);
    else pass_cnt++;
    chk_cnt++;
    if (bus.pad_data_n !== 1'b1) $display("FAIL glitch_data_n: got %b expected 1", bus.pad_data_n);
    else pass_cnt++;
    // A two-cycle pulse is the shortest one that is accepted.
    bus.pad_clk = 1'b1;
    step(2);
    bus.pad_clk = 1'b0;
    step(12);
    chk_cnt++;
    if (bus.bit_count !== 4'd3) $display("FAIL min_pulse_count: got %0d expected 3", bus.bit_count);
    else pass_cnt++;
  endtask

  task automatic test_rewrite();
    write_buttons(8'hFF);
    do_latch();
    for (int i = 0; i < 3; i++) pulse_clk();
    write_buttons(8'h00);
    chk_cnt++;
    if (bus.pad_data_n !== 1'b0) $display("FAIL rewrite_inflight: got %b expected 0", bus.pad_data_n);
    else pass_cnt++;
    chk_cnt++;
    if (bus.bit_count !== 4'd3) $display("FAIL rewrite_inflight_count: got %0d expected 3", bus.bit_count);
    else pass_cnt++;
    do_latch();
    chk_cnt++;
    if (bus.pad_data_n !== 1'b1) $display("FAIL rewrite_first_bit: got %b expected 1", bus.pad_data_n);
    else pass_cnt++;
    chk_cnt++;
    if (bus.bit_count !== 4'd0) $display("FAIL rewrite_count: got %0d expected 0", bus.bit_count);
    else pass_cnt++;
  endtask

  task automatic test_latch_write();
    bus.pad_latch = 1'b1;
    step(20);
    write_buttons(8'h01);
    chk_cnt++;
    if (bus.pad_data_n !== 1'b0) $display("FAIL latch_write_same_edge: got %b expected 0", bus.pad_data_n);
    else pass_cnt++;
    bus.pad_latch = 1'b0;
    step(PH);
    pulse_clk();
    chk_cnt++;
    if (bus.pad_data_n !== 1'b1 || bus.bit_count !== 4'd1) $display("FAIL latch_write_shift: got %b/%0d expected 1/1", bus.pad_data_n, bus.bit_count);
    else pass_cnt++;
  endtask

  // Starts mid-read with hold = 8'h01.
  task automatic test_simultaneous();
    bus.pad_latch = 1'b1;
    bus.pad_clk   = 1'b1;
    step(20);
    bus.pad_latch = 1'b0;
    bus.pad_clk   = 1'b0;
    step(PH);
    chk_cnt++;
    if (bus.bit_count !== 4'd0) $display("FAIL simul_count: got %0d expected 0", bus.bit_count);
    else pass_cnt++;
    chk_cnt++;
    if (bus.pad_data_n !== 1'b0) $display("FAIL simul_data_n: got %b expected 0", bus.pad_data_n);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    write_buttons(8'hFF);
    do_latch();
    for (int i = 0; i < 4; i++) pulse_clk();
    chk_cnt++;
    if (bus.bit_count !== 4'd4 || bus.pad_data_n !== 1'b0) $display("FAIL midrst_pre: got %0d/%b expected 4/0", bus.bit_count, bus.pad_data_n);
    else pass_cnt++;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_cnt++;
    if (bus.pad_data_n !== 1'b1) $display("FAIL midrst_data_n: got %b expected 1", bus.pad_data_n);
    else pass_cnt++;
    chk_cnt++;
    if (bus.bit_count !== 4'd8) $display("FAIL midrst_count: got %0d expected 8", bus.bit_count);
    else pass_cnt++;
    step(5);
    do_latch();
    for (int i = 0; i < 8; i++) begin
      chk_cnt++;
      if (bus.pad_data_n !== 1'b1) $display("FAIL midrst_bit%0d: got %b expected 1", i, bus.pad_data_n);
      else pass_cnt++;
      pulse_clk();
    end
    chk_cnt++;
    if (bus.bit_count !== 4'd8 || bus.pad_data_n !== 1'b0) $display("FAIL midrst_end: got %0d/%b expected 8/0", bus.bit_count, bus.pad_data_n);
    else pass_cnt++;
  endtask

  initial begin
    bus.buttons    = 8'h00;
    bus.buttons_we = 1'b0;
    bus.pad_latch  = 1'b0;
    bus.pad_clk    = 1'b0;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(2);
    test_reset();
    test_read_81();
    test_extra_reads();
    test_glitch();
    test_rewrite();
    test_latch_write();
    test_simultaneous();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
